// File: rtl/min_exec_unit_p.sv
// Multi-cycle MIN execution unit: fetch/decode/execute FSM with a register file,
// NZVC flags and a req/ack port to a unified instruction/data memory.
module min_exec_unit_p #(
  parameter int DW   = 16,
  parameter int NREG = 16,
  parameter int AW   = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          run,
  input  logic [AW-1:0] pc_init,
  input  logic          init_we,
  input  logic [3:0]    init_sel,
  input  logic [DW-1:0] init_data,
  output logic [DW-1:0] dbg_data,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic [AW-1:0] pc,
  output logic [15:0]   ir,
  output logic          z,
  output logic          n,
  output logic          c,
  output logic          v,
  output logic          halted,
  output logic          illegal
);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXT, S_ADDR, S_MRD, S_EXEC, S_MWR, S_HALT
  } state_t;

  localparam logic [5:0] OP_HALT = 6'h00, OP_LD  = 6'h01, OP_ST  = 6'h02,
                         OP_TST  = 6'h03, OP_BRZ = 6'h05, OP_BRA = 6'h06,
                         OP_ADD  = 6'h0C, OP_SUB = 6'h14, OP_AND = 6'h1C,
                         OP_OR   = 6'h24, OP_XOR = 6'h2C;
  localparam logic [4:0] NREG_L = 5'(NREG);

  state_t state, state_nxt;

  // Always 16 entries so 4-bit indices stay in range; entries >= NREG are never written.
  logic [DW-1:0] regs [16];
  logic [DW-1:0] t;
  logic [DW-1:0] opnd;
  logic [AW-1:0] ea;

  logic [5:0] op;
  logic [3:0] rx, ry;
  logic [1:0] mode;
  logic [DW-1:0] rx_val, ry_val;
  logic [AW-1:0] ea_calc;
  logic op_legal, is_alu, bad_reg, bad_mode, is_illegal, needs_mrd;
  logic [DW:0] sum, diff;
  logic [DW-1:0] alu_res;
  logic alu_c, alu_v;

  assign op     = ir[15:10];
  assign rx     = ir[9:6];
  assign mode   = ir[5:4];
  assign ry     = ir[3:0];
  assign rx_val = regs[rx];
  assign ry_val = regs[ry];
  assign ea_calc = (mode == 2'b10) ? ry_val[AW-1:0] + t[AW-1:0] : ry_val[AW-1:0];
  assign sum    = {1'b0, rx_val} + {1'b0, opnd};
  assign diff   = {1'b0, rx_val} - {1'b0, opnd};
  assign dbg_data = regs[init_sel];
  assign halted   = (state == S_HALT);

  always_comb begin
    op_legal = 1'b0;
    is_alu   = 1'b0;
    case (op)
      OP_HALT, OP_LD, OP_ST, OP_TST, OP_BRZ, OP_BRA: op_legal = 1'b1;
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
        op_legal = 1'b1;
        is_alu   = 1'b1;
      end
      default: ;
    endcase
    bad_reg    = ({1'b0, rx} >= NREG_L) || ({1'b0, ry} >= NREG_L);
    bad_mode   = ((op == OP_ST || op == OP_BRZ || op == OP_BRA) && mode == 2'b11) ||
                 (op == OP_ST && mode == 2'b00);
    is_illegal = !op_legal || bad_reg || bad_mode;
    needs_mrd  = (mode == 2'b01 || mode == 2'b10) && (op == OP_LD || op == OP_TST || is_alu);
  end

  // SUB carry is the borrow bit of the widened difference.
  always_comb begin
    alu_res = rx_val;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res = sum[DW-1:0];
        alu_c   = sum[DW];
        alu_v   = (rx_val[DW-1] == opnd[DW-1]) && (sum[DW-1] != rx_val[DW-1]);
      end
      OP_SUB: begin
        alu_res = diff[DW-1:0];
        alu_c   = diff[DW];
        alu_v   = (rx_val[DW-1] != opnd[DW-1]) && (diff[DW-1] != rx_val[DW-1]);
      end
      OP_AND: alu_res = rx_val & opnd;
      OP_OR:  alu_res = rx_val | opnd;
      OP_XOR: alu_res = rx_val ^ opnd;
      default: ;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (run) state_nxt = S_FETCH;
      S_FETCH:  if (mem_ack) state_nxt = S_DECODE;
      S_DECODE: begin
        if (is_illegal || op == OP_HALT) state_nxt = S_HALT;
        else if (mode[1])                state_nxt = S_EXT;
        else                             state_nxt = S_ADDR;
      end
      S_EXT:    if (mem_ack) state_nxt = S_ADDR;
      S_ADDR:   state_nxt = needs_mrd ? S_MRD : S_EXEC;
      S_MRD:    if (mem_ack) state_nxt = S_EXEC;
      S_EXEC:   state_nxt = (op == OP_ST) ? S_MWR : S_FETCH;
      S_MWR:    if (mem_ack) state_nxt = S_FETCH;
      S_HALT:   state_nxt = S_HALT;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Bus outputs come straight from registered state, so they hold until accepted.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      S_FETCH, S_EXT: begin
        mem_req  = 1'b1;
        mem_addr = pc;
      end
      S_MRD: begin
        mem_req  = 1'b1;
        mem_addr = ea;
      end
      S_MWR: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = ea;
        mem_wdata = rx_val;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      pc      <= pc_init;
      ir      <= '0;
      t       <= '0;
      opnd    <= '0;
      ea      <= '0;
      z       <= 1'b0;
      n       <= 1'b0;
      c       <= 1'b0;
      v       <= 1'b0;
      illegal <= 1'b0;
      for (int i = 0; i < 16; i++) regs[i] <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE:
          if (init_we && ({1'b0, init_sel} < NREG_L)) regs[init_sel] <= init_data;
        S_FETCH:
          if (mem_ack) begin
            ir <= mem_rdata[15:0];
            pc <= pc + AW'(1);
          end
        S_DECODE:
          if (is_illegal) illegal <= 1'b1;
        S_EXT:
          if (mem_ack) begin
            t  <= mem_rdata;
            pc <= pc + AW'(1);
          end
        S_ADDR: begin
          ea   <= ea_calc;
          opnd <= (mode == 2'b11) ? t : ry_val;
        end
        S_MRD:
          if (mem_ack) opnd <= mem_rdata;
        S_EXEC: begin
          case (op)
            OP_LD:  regs[rx] <= opnd;
            OP_TST: begin
              z <= (opnd == '0);
              n <= opnd[DW-1];
              c <= 1'b0;
              v <= 1'b0;
            end
            OP_BRZ: if (z) pc <= ea;
            OP_BRA: pc <= ea;
            default:
              if (is_alu) begin
                regs[rx] <= alu_res;
                z        <= (alu_res == '0);
                n        <= alu_res[DW-1];
                c        <= alu_c;
                v        <= alu_v;
              end
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule
